// File: rtl/inst_mem_loader.sv
// Assembles MSB-first UART bytes into instruction words and writes them to
// instruction memory from address 0 until the HALT word or memory end.
module inst_mem_loader #(
    parameter int unsigned PC_BITS          = 32,
    parameter int unsigned INSTRUCTION_BITS = 32,
    parameter int unsigned INST_ADDRS_BITS  = 10,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_INST = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_done,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overflow
);

    localparam int unsigned N_BYTES = INSTRUCTION_BITS / 8;
    localparam int unsigned CNT_W   = $clog2(N_BYTES + 1);
    localparam logic [INST_ADDRS_BITS-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                      state, state_next;
    logic [CNT_W-1:0]            byte_cnt;
    logic [INSTRUCTION_BITS-1:0] shift;
    logic [INSTRUCTION_BITS-1:0] shift_in;
    logic [INST_ADDRS_BITS-1:0]  addr;

    assign shift_in        = (shift << 8) | INSTRUCTION_BITS'(i_rx_data);
    assign o_inst_mem_addr = PC_BITS'(addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (i_start) state_next = RECV;
            RECV:       if (i_rx_done && byte_cnt == LAST_BYTE) state_next = WRITE;
            WRITE: begin
                if (shift == HALT_INST || addr == LAST_ADDR) state_next = DONE;
                else                                         state_next = RECV;
            end
            default:    state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt         <= '0;
            shift            <= '0;
            addr             <= '0;
            o_write_inst_mem <= 1'b0;
            o_inst_mem_data  <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_overflow       <= 1'b0;
        end else begin
            o_write_inst_mem <= (state_next == WRITE);
            o_busy           <= (state_next == RECV) || (state_next == WRITE);
            o_done           <= (state_next == DONE);
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        addr       <= '0;
                        byte_cnt   <= '0;
                        shift      <= '0;
                        o_overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (i_rx_done) begin
                        shift <= shift_in;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt        <= '0;
                            o_inst_mem_data <= shift_in;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (state_next == DONE) begin
                        o_overflow <= (shift != HALT_INST);
                    end else begin
                        addr <= addr + INST_ADDRS_BITS'(1);
                        // A byte arriving during the write opens the next word.
                        if (i_rx_done) begin
                            shift    <= shift_in;
                            byte_cnt <= CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench: two loaders (default depth and depth 4) share stimulus
// and are compared every cycle against a word-level reference model.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;

    logic        w0, w1, bz0, bz1, dn0, dn1, ov0, ov1;
    logic [31:0] a0, a1, d0, d1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done), .o_write_inst_mem(w0), .o_inst_mem_addr(a0),
        .o_inst_mem_data(d0), .o_busy(bz0), .o_done(dn0), .o_overflow(ov0)
    );

    inst_mem_loader #(.INST_ADDRS_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done), .o_write_inst_mem(w1), .o_inst_mem_addr(a1),
        .o_inst_mem_data(d1), .o_busy(bz1), .o_done(dn1), .o_overflow(ov1)
    );

    // Reference model: a loader is either inactive or gathering bytes into a
    // word; a completed word costs one write cycle before the next decision.
    int unsigned depth [2] = '{1024, 4};
    bit          m_loading [2];
    bit          m_write   [2];
    bit          m_done    [2];
    bit          m_ovf     [2];
    int unsigned m_nbytes  [2];
    int unsigned m_addr    [2];
    logic [31:0] m_word    [2];
    logic [31:0] m_last    [2];

    typedef struct { int unsigned addr; logic [31:0] data; } wr_t;
    wr_t wq[$];
    int  small_writes;

    typedef struct { logic [31:0] word; int unsigned exp_addr; logic [31:0] exp_data; } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_loading[k] = 0; m_write[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
            m_nbytes[k] = 0; m_addr[k] = 0; m_word[k] = '0; m_last[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input bit s, input bit d, input logic [7:0] b);
        if (m_write[k]) begin
            m_write[k] = 0;
            if (m_last[k] == 32'hFFFF_FFFF) begin
                m_loading[k] = 0; m_done[k] = 1; m_ovf[k] = 0;
            end else if (m_addr[k] == depth[k] - 1) begin
                m_loading[k] = 0; m_done[k] = 1; m_ovf[k] = 1;
            end else begin
                m_addr[k]++;
                m_word[k]   = d ? {24'h0, b} : '0;
                m_nbytes[k] = d ? 1 : 0;
            end
        end else if (m_loading[k]) begin
            if (d) begin
                m_word[k] = m_word[k] * 256 + {24'h0, b};
                m_nbytes[k]++;
                if (m_nbytes[k] == 4) begin
                    m_write[k] = 1; m_last[k] = m_word[k]; m_nbytes[k] = 0;
                end
            end
        end else if (s) begin
            m_loading[k] = 1; m_done[k] = 0; m_ovf[k] = 0;
            m_addr[k] = 0; m_nbytes[k] = 0; m_word[k] = '0;
        end
    endtask

    task automatic check_all();
        check("write0", w0, m_write[0]);  check("write1", w1, m_write[1]);
        check("addr0", a0, m_addr[0]);    check("addr1", a1, m_addr[1]);
        check("busy0", bz0, m_loading[0]); check("busy1", bz1, m_loading[1]);
        check("done0", dn0, m_done[0]);   check("done1", dn1, m_done[1]);
        check("ovf0", ov0, m_ovf[0]);     check("ovf1", ov1, m_ovf[1]);
        if (m_write[0]) check("data0", d0, m_last[0]);
        if (m_write[1]) check("data1", d1, m_last[1]);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic tick(input bit s, input bit d, input logic [7:0] b);
        i_start = s; i_rx_done = d; i_rx_data = b;
        @(posedge clk);
        model_step(0, s, d, b);
        model_step(1, s, d, b);
        @(negedge clk);
        i_start = 1'b0; i_rx_done = 1'b0;
        check_all();
        if (w0) wq.push_back('{a0, d0});
        if (w1) small_writes++;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, w[31-8*i -: 8]);
            repeat (gap) tick(0, 0, 8'h00);
        end
    endtask

    initial begin
        rst = 1'b0; i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = '0;
        model_reset();
        vecs[0] = '{32'h0000_0001, 0, 32'h0000_0001};
        vecs[1] = '{32'h1234_5678, 1, 32'h1234_5678};
        vecs[2] = '{32'hFFFF_FFFF, 2, 32'hFFFF_FFFF};
        #1;
        check("reset busy", bz0, 0); check("reset write", w0, 0);
        check("reset addr", a0, 0);  check("reset data", d0, 0);
        check("reset done", dn0, 0); check("reset ovf", ov0, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Bytes before start are ignored.
        send_word(32'hDEAD_BEEF, 0);
        check("idle writes", wq.size(), 0);

        // Table-driven load ending in HALT.
        tick(1, 0, 8'h00);
        for (int v = 0; v < 3; v++) send_word(vecs[v].word, v);
        repeat (2) tick(0, 0, 8'h00);
        check("t1 nwrites", wq.size(), 3);
        for (int v = 0; v < 3 && v < wq.size(); v++) begin
            check("t1 addr", wq[v].addr, vecs[v].exp_addr);
            check("t1 data", wq[v].data, vecs[v].exp_data);
        end
        check("t1 done", dn0, 1); check("t1 ovf", ov0, 0); check("t1 busy", bz0, 0);

        // Start with a coincident byte in DONE: start wins, byte ignored.
        wq.delete();
        tick(1, 1, 8'h5A);
        check("t6 done clr", dn0, 0); check("t6 busy", bz0, 1);
        // Start mid-word is ignored; latency of write pulse.
        tick(0, 1, 8'hAA); tick(1, 0, 8'h00); tick(0, 1, 8'hBB);
        tick(0, 1, 8'hCC); tick(0, 0, 8'h00);
        check("t2 no early write", w0, 0);
        tick(0, 1, 8'hDD);
        check("t2 write pulse", w0, 1); check("t2 data", d0, 32'hAABB_CCDD);
        check("t2 addr", a0, 0);
        tick(0, 0, 8'h00);
        check("t2 pulse width", w0, 0);
        send_word(32'hFFFF_FFFF, 1);
        tick(0, 0, 8'h00);
        check("t2 nwrites", wq.size(), 2);

        // Byte strobed during the write cycle begins the next word.
        wq.delete();
        tick(1, 0, 8'h00);
        send_word(32'h1122_3344, 0);
        tick(0, 1, 8'h99);
        tick(0, 1, 8'h55); tick(0, 1, 8'h66); tick(0, 1, 8'h77);
        tick(0, 0, 8'h00);
        send_word(32'hFFFF_FFFF, 0);
        tick(0, 0, 8'h00);
        check("t4 nwrites", wq.size(), 3);
        if (wq.size() >= 2) begin
            check("t4 w0 data", wq[0].data, 32'h1122_3344);
            check("t4 w1 addr", wq[1].addr, 1);
            check("t4 w1 data", wq[1].data, 32'h9955_6677);
        end

        // Depth-4 loader overflows on the fifth word.
        wq.delete(); small_writes = 0;
        tick(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) send_word(32'h0102_0304 + i, 1);
        tick(0, 0, 8'h00);
        check("t3 small writes", small_writes, 4);
        check("t3 small done", dn1, 1); check("t3 small ovf", ov1, 1);
        check("t3 small addr", a1, 3);
        check("t3 big writes", wq.size(), 5);
        send_word(32'hFFFF_FFFF, 0);
        tick(0, 0, 8'h00);

        // Asynchronous reset mid-word.
        tick(1, 0, 8'h00);
        send_word(32'h0BAD_F00D, 0);
        tick(0, 0, 8'h00);
        tick(0, 1, 8'h12); tick(0, 1, 8'h34);
        #2 rst = 1'b0;
        #1;
        check("t5 busy0", bz0, 0); check("t5 addr0", a0, 0);
        check("t5 done0", dn0, 0); check("t5 data0", d0, 0);
        check("t5 busy1", bz1, 0); check("t5 addr1", a1, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        tick(1, 0, 8'h00);
        send_word(32'hCAFE_F00D, 0);
        tick(0, 0, 8'h00);
        check("t5 nwrites", wq.size(), 1);
        if (wq.size() == 1) check("t5 restart addr", wq[0].addr, 0);

        // Randomised traffic with heavy use of 0xFF so HALT words occur.
        for (int c = 0; c < 3000; c++) begin
            bit s, d;
            logic [7:0] b;
            s = ($urandom_range(0, 39) == 0);
            d = ($urandom_range(0, 1) == 1);
            b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            tick(s, d, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
